gate_vector_checker: RTL
========================

GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 The block SHALL provide parameter PASSES, default 4, the number of full sweeps of the 4 input vectors, legal range 1..15.
REQ-002 The block SHALL provide port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-004 The block SHALL provide port start, input, 1 bit, a one-cycle request to begin a run.
REQ-005 The block SHALL provide port gate_sel, input, 3 bits, the gate under test: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110/111 invalid.
REQ-006 The block SHALL provide port dut_out, input, 1 bit, the output of the gate under test.
REQ-007 The block SHALL provide port in1, output, 1 bit, the first stimulus bit to the gate under test.
REQ-008 The block SHALL provide port in2, output, 1 bit, the second stimulus bit to the gate under test.
REQ-009 The block SHALL provide port busy, output, 1 bit, high while a run is in progress.
REQ-010 The block SHALL provide port done, output, 1 bit, a one-cycle pulse at the end of a run.
REQ-011 The block SHALL provide port pass, output, 1 bit, the result of the last run, held until the next accepted start.
REQ-012 The block SHALL provide port err_count, output, 6 bits, the number of mismatches in the current or last run.
REQ-013 The block SHALL provide port first_err_vec, output, 2 bits, {in1,in2} at the first mismatch of the current or last run.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 IDLE: start=1 SHALL be accepted on the clock edge; gate_sel SHALL be latched internally, err_count and first_err_vec cleared, pass cleared.
REQ-016 IDLE transitions: valid gate_sel goes to DRIVE with vector 00 and pass index 0; invalid gate_sel goes directly to DONE.
REQ-017 DRIVE SHALL last 1 cycle with {in1,in2} = current vector (settle cycle), then go to SAMPLE.
REQ-018 SAMPLE SHALL last 1 cycle with the same vector held.
REQ-019 On the edge leaving SAMPLE, dut_out SHALL be compared to the latched-gate function of the vector; a mismatch SHALL increment err_count.
REQ-020 On the first mismatch of a run, first_err_vec SHALL capture the vector.
REQ-021 Vector order SHALL be 00, 01, 10, 11 ({in1,in2}); after 11 the vector SHALL wrap to 00 and the pass index SHALL increment.
REQ-022 After SAMPLE of vector 11 in pass PASSES-1 the FSM SHALL go to DONE; otherwise it SHALL return to DRIVE.
REQ-023 DONE SHALL last 1 cycle: done=1, pass=(err_count==0) for a valid gate_sel and 0 for an invalid one; then IDLE.
REQ-024 Latency: for a start accepted at edge 0, busy SHALL be high cycles 1..8*PASSES and done SHALL be high in cycle 8*PASSES+1.
REQ-025 busy SHALL be 1 only in DRIVE/SAMPLE; in1=in2=0 in IDLE and DONE.
REQ-026 start outside IDLE SHALL be ignored; gate_sel changes during a run SHALL have no effect.
REQ-027 err_count SHALL NOT overflow (max 4*15=60); no saturation logic is required.
REQ-028 first_err_vec SHALL remain 00 when no mismatch occurs.

Reset
REQ-029 While rst=1, regardless of clk, the FSM SHALL be in IDLE and all outputs SHALL be 0: in1, in2, busy, done, pass, err_count, first_err_vec.
REQ-030 rst asserted mid-run SHALL abort the run with no done pulse; the first start after rst deasserts SHALL run a full sweep from vector 00, pass 0.

Verification
REQ-031 AND, dut_out = in1&in2 model, PASSES=4, start: busy cycles 1..32, done in cycle 33, pass=1, err_count=0, first_err_vec=00.
REQ-032 AND, dut_out tied 0: err_count=4, first_err_vec=11, pass=0 at done.
REQ-033 OR, dut_out tied 1: err_count=4, first_err_vec=00, pass=0; XNOR, dut_out=in1^in2: err_count=16, first_err_vec=00.
REQ-034 gate_sel=110, start: done in cycle 1, busy never high, pass=0, err_count=0.
REQ-035 rst pulsed during pass 2 of AND: outputs 0 immediately, no done; re-start: full 32-cycle run, pass=1.
REQ-036 start re-pulsed at cycle 10 of a run: ignored, done still in cycle 33, err_count unchanged by the pulse.

Source files
------------

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: exhaustively sweeps the four input vectors of a
// two-input gate for a configurable number of passes. It compares the gate's
// response against the function selected at start, then reports the mismatch
// count, the first failing vector and an overall pass flag.

module gate_vector_checker #(
  parameter int PASSES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       dut_out,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_count,
  output logic [1:0] first_err_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] LAST_PASS = 4'(PASSES - 1);

  localparam logic [2:0] GATE_AND  = 3'b000;
  localparam logic [2:0] GATE_OR   = 3'b001;
  localparam logic [2:0] GATE_NAND = 3'b010;
  localparam logic [2:0] GATE_NOR  = 3'b011;
  localparam logic [2:0] GATE_XOR  = 3'b100;
  localparam logic [2:0] GATE_XNOR = 3'b101;

  state_t     state;
  logic [2:0] gate_lat;
  logic [1:0] vec;
  logic [3:0] pass_idx;

  logic expected_out;
  logic mismatch;
  logic last_step;

  // Reference response of the latched gate for a given {in1,in2} vector.
  function automatic logic gate_func(input logic [2:0] g, input logic [1:0] v);
    logic a;
    logic b;
    logic r;
    a = v[1];
    b = v[0];
    case (g)
      GATE_AND:  r = a & b;
      GATE_OR:   r = a | b;
      GATE_NAND: r = ~(a & b);
      GATE_NOR:  r = ~(a | b);
      GATE_XOR:  r = a ^ b;
      GATE_XNOR: r = ~(a ^ b);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Compare the observed gate output with the reference and spot the final step.
  always_comb begin
    expected_out = gate_func(gate_lat, vec);
    mismatch     = (dut_out != expected_out);
    last_step    = (vec == 2'b11) && (pass_idx == LAST_PASS);
  end

  // Run sequencer: every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      gate_lat      <= 3'b000;
      vec           <= 2'b00;
      pass_idx      <= 4'd0;
      in1           <= 1'b0;
      in2           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= 6'd0;
      first_err_vec <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          in1  <= 1'b0;
          in2  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            gate_lat      <= gate_sel;
            err_count     <= 6'd0;
            first_err_vec <= 2'b00;
            pass          <= 1'b0;
            vec           <= 2'b00;
            pass_idx      <= 4'd0;
            if (gate_sel <= GATE_XNOR) begin
              state <= DRIVE;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        DRIVE: begin
          state <= SAMPLE;
        end

        SAMPLE: begin
          if (mismatch) begin
            err_count <= err_count + 6'd1;
            if (err_count == 6'd0) begin
              first_err_vec <= vec;
            end
          end
          if (last_step) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            in1   <= 1'b0;
            in2   <= 1'b0;
            pass  <= (err_count == 6'd0) && !mismatch;
          end else begin
            state      <= DRIVE;
            vec        <= vec + 2'd1;
            {in1, in2} <= vec + 2'd1;
            if (vec == 2'b11) begin
              pass_idx <= pass_idx + 4'd1;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
